// File: rtl/bcd_updown_counter_debounce_if.sv
// Button inputs and BCD display outputs of the up/down event counter.
interface bcd_updown_counter_debounce_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    add1;
  logic                    sub1;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    wrap;

  modport master (
    output add1,
    output sub1,
    input  digits,
    input  wrap
  );

  modport slave (
    input  add1,
    input  sub1,
    output digits,
    output wrap
  );
endinterface

// File: rtl/bcd_updown_counter_debounce.sv
// Debounced two-button BCD up/down counter with wrap/limit pulse.
// Define BCD_COUNTER_SATURATE_EN to saturate at 0 and 10^N-1 instead of wrapping.
module bcd_updown_counter_debounce #(
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic ck,
  input logic reset,
  bcd_updown_counter_debounce_if.slave bus
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES-1);

  // bit 0 = add button, bit 1 = sub button
  logic [1:0]    raw, s1, s2, lvl, prev, press;
  logic [CW-1:0] cnt [2];

  assign raw   = {bus.sub1, bus.add1};
  assign press = prev & ~lvl;

  always_ff @(posedge ck) begin
    if (!reset) begin
      s1   <= '1;
      s2   <= '1;
      lvl  <= '1;
      prev <= '1;
      for (int b = 0; b < 2; b++)
        cnt[b] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= lvl;
      for (int b = 0; b < 2; b++) begin
        if (s2[b] == lvl[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CMAX) begin
          lvl[b] <= s2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  logic [W-1:0] q, inc, dec;
  logic         all9, all0, cy, bw, wr;

  // Ripple carry/borrow across digits in a single cycle.
  always_comb begin
    inc  = '0;
    dec  = '0;
    all9 = 1'b1;
    all0 = 1'b1;
    cy   = 1'b1;
    bw   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (q[4*k +: 4] != 4'd9) all9 = 1'b0;
      if (q[4*k +: 4] != 4'd0) all0 = 1'b0;
      if (!cy)
        inc[4*k +: 4] = q[4*k +: 4];
      else if (q[4*k +: 4] == 4'd9)
        inc[4*k +: 4] = 4'd0;
      else
        inc[4*k +: 4] = q[4*k +: 4] + 4'd1;
      if (!bw)
        dec[4*k +: 4] = q[4*k +: 4];
      else if (q[4*k +: 4] == 4'd0)
        dec[4*k +: 4] = 4'd9;
      else
        dec[4*k +: 4] = q[4*k +: 4] - 4'd1;
      cy = cy & (q[4*k +: 4] == 4'd9);
      bw = bw & (q[4*k +: 4] == 4'd0);
    end
  end

  logic up, dn;
  assign up = press[0] & ~press[1];
  assign dn = press[1] & ~press[0];

  always_ff @(posedge ck) begin
    if (!reset) begin
      q  <= '0;
      wr <= 1'b0;
    end else begin
      wr <= 1'b0;
`ifdef BCD_COUNTER_SATURATE_EN
      if (up) begin
        if (all9) wr <= 1'b1;
        else      q  <= inc;
      end else if (dn) begin
        if (all0) wr <= 1'b1;
        else      q  <= dec;
      end
`else
      if (up) begin
        q  <= inc;
        wr <= all9;
      end else if (dn) begin
        q  <= dec;
        wr <= all0;
      end
`endif
    end
  end

  assign bus.digits = q;
  assign bus.wrap   = wr;
endmodule

// File: tb/tb_bcd_updown_counter_debounce.sv
// Bench for bcd_updown_counter_debounce: vector table, corner sequences
// and random presses/glitches against an arithmetic count model.
`timescale 1ns/100ps
module tb_bcd_updown_counter_debounce;
  logic ck = 1'b0;
  logic reset = 1'b0;
  always #1 ck = ~ck;

  bcd_updown_counter_debounce_if #(.NUM_DIGITS(2)) bus ();

  bcd_updown_counter_debounce #(
    .NUM_DIGITS(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .ck(ck),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int wcnt   = 0;
  int model  = 0;

  typedef struct {
    bit         a;
    bit         s;
    logic [7:0] exp;
    bit         w;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the buttons for n cycles, counting wrap pulses seen.
  task automatic seg(bit a_low, bit s_low, int n);
    bus.add1 = !a_low;
    bus.sub1 = !s_low;
    repeat (n) begin
      @(negedge ck);
      if (bus.wrap) wcnt++;
    end
  endtask

  task automatic do_reset(bit hold_add);
    bus.add1 = !hold_add;
    bus.sub1 = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge ck);
    reset = 1'b1;
    model = 0;
  endtask

  function automatic logic [7:0] bcd(int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Apply one press of a given direction to the model count.
  function automatic int step(int c, bit up, output bit w);
`ifdef BCD_COUNTER_SATURATE_EN
    w = up ? (c == 99) : (c == 0);
    if (!w) c = up ? c + 1 : c - 1;
`else
    w = up ? (c == 99) : (c == 0);
    c = up ? (c + 1) % 100 : (c + 99) % 100;
`endif
    return c;
  endfunction

  // kind: 0 add, 1 sub, 2 add glitch, 3 sub glitch, 4 bouncy add, 5 bouncy sub
  task automatic op(int kind, string name);
    bit w = 1'b0;
    bit a = (kind % 2) == 0;
    wcnt = 0;
    if (kind < 2) begin
      model = step(model, a, w);
      seg(a, !a, 10);
    end else if (kind < 4) begin
      seg(a, !a, $urandom_range(1, 3));
    end else begin
      model = step(model, a, w);
      seg(a, !a, $urandom_range(1, 3));
      seg(0, 0, $urandom_range(1, 2));
      seg(a, !a, $urandom_range(1, 3));
      seg(0, 0, 1);
      seg(a, !a, 10);
    end
    seg(0, 0, 10);
    chk({name, " digits"}, 32'(bus.digits), 32'(bcd(model)));
    chk({name, " wrap"}, wcnt, 32'(w));
  endtask

  initial begin
`ifdef BCD_COUNTER_SATURATE_EN
    tbl[0] = '{0, 1, 8'h00, 1};
    tbl[1] = '{1, 0, 8'h01, 0};
    tbl[2] = '{1, 0, 8'h02, 0};
    tbl[3] = '{0, 1, 8'h01, 0};
    tbl[4] = '{0, 1, 8'h00, 0};
    tbl[5] = '{0, 1, 8'h00, 1};
    tbl[6] = '{1, 0, 8'h01, 0};
    tbl[7] = '{0, 1, 8'h00, 0};
`else
    tbl[0] = '{0, 1, 8'h99, 1};
    tbl[1] = '{1, 0, 8'h00, 1};
    tbl[2] = '{1, 0, 8'h01, 0};
    tbl[3] = '{1, 0, 8'h02, 0};
    tbl[4] = '{0, 1, 8'h01, 0};
    tbl[5] = '{0, 1, 8'h00, 0};
    tbl[6] = '{0, 1, 8'h99, 1};
    tbl[7] = '{1, 0, 8'h00, 1};
`endif
    bus.add1 = 1'b1;
    bus.sub1 = 1'b1;
    @(negedge ck);

    do_reset(0);
    chk("reset digits", 32'(bus.digits), 0);
    chk("reset wrap", 32'(bus.wrap), 0);

    // Short glitch then bounce: no count.
    wcnt = 0;
    seg(1, 0, 3); seg(0, 0, 10);
    seg(1, 0, 1); seg(0, 0, 1); seg(1, 0, 1); seg(0, 0, 10);
    chk("glitch digits", 32'(bus.digits), 0);

    // Press latency: update at exactly E+6.
    seg(1, 0, 6);
    chk("latency E+5", 32'(bus.digits), 32'h00);
    seg(1, 0, 1);
    chk("latency E+6", 32'(bus.digits), 32'h01);
    seg(1, 0, 4);
    seg(0, 0, 10);
    chk("held once", 32'(bus.digits), 32'h01);
    chk("held wrap", wcnt, 0);

    // Button held through reset counts once.
    do_reset(1);
    chk("rst held in", 32'(bus.digits), 0);
    seg(1, 0, 10);
    seg(0, 0, 10);
    chk("rst held out", 32'(bus.digits), 32'h01);

    do_reset(0);
    foreach (tbl[i]) begin
      wcnt = 0;
      seg(tbl[i].a, tbl[i].s, 10);
      seg(0, 0, 10);
      chk($sformatf("vec%0d digits", i), 32'(bus.digits), 32'(tbl[i].exp));
      chk($sformatf("vec%0d wrap", i), wcnt, 32'(tbl[i].w));
    end

    // Walk up to 99 through every BCD carry, then past the limit.
    do_reset(0);
    for (int i = 0; i < 100; i++)
      op(0, $sformatf("up%0d", i));
    op(1, "down");
    op(0, "up99");

    for (int i = 0; i < 60; i++)
      op($urandom_range(0, 5), $sformatf("rnd%0d", i));

    // Simultaneous and staggered presses from 42.
    do_reset(0);
    for (int i = 0; i < 42; i++)
      op(0, $sformatf("to42_%0d", i));
    wcnt = 0;
    seg(1, 1, 10);
    seg(0, 0, 10);
    chk("simul digits", 32'(bus.digits), 32'h42);
    chk("simul wrap", wcnt, 0);
    seg(1, 0, 1);
    seg(1, 1, 6);
    chk("stagger add", 32'(bus.digits), 32'h43);
    seg(1, 1, 4);
    seg(0, 0, 10);
    chk("stagger sub", 32'(bus.digits), 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
